// File: rtl/uart_rx_line_assembler.sv
// uart_rx_line_assembler
// Reads bytes from a CoreUART receiver (non-FIFO mode) by strobing CSN/OEN.
// Assembles the bytes into a line buffer until a terminator byte arrives or
// the buffer fills. The line is then held for the system side until line_ack.
module uart_rx_line_assembler #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] TERM     = 8'h0A,
  parameter bit         STRIP_CR = 1'b1,
  parameter int         LEN_W    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RXRDY,
  input  logic [7:0]       UART_DATA,
  input  logic             PARITY_ERR,
  input  logic             FRAMING_ERR,
  input  logic             OVERFLOW,
  output logic             CSN,
  output logic             OEN,
  output logic             line_ready,
  output logic [LEN_W-1:0] line_len,
  output logic             line_err,
  output logic             line_trunc,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data,
  input  logic             line_ack
);

  localparam int               ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L    = LEN_W'(DEPTH);
  localparam logic [1:0]       SETTLE_MAX = 2'd3;  // 4 cycles in SETTLE at most
  localparam logic [7:0]       CR         = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SETTLE,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic             strobe_n_q;    // shared CSN/OEN strobe, active low
  logic             line_ready_q;
  logic             err_q;
  logic             trunc_q;
  logic [LEN_W-1:0] count_q;
  logic [1:0]       settle_q;
  logic [7:0]       rd_data_q;
  logic [7:0]       buf_mem [DEPTH];

  logic [LEN_W-1:0] count_d;
  logic             is_term;
  logic             is_cr;
  logic             byte_err;
  logic             store_en;

  // Classify the byte currently presented by the UART during READ.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so no latch is inferred on any path.
    count_d  = count_q + LEN_W'(1);
    is_term  = (UART_DATA == TERM);
    is_cr    = STRIP_CR && (UART_DATA == CR);
    byte_err = PARITY_ERR | FRAMING_ERR | OVERFLOW;
    store_en = (state_q == S_READ) && !is_term && !is_cr;
  end

  // Control FSM: UART strobe, line bookkeeping and handshake with the system.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // the pre-edge value of every other register.
    if (RESET) begin
      state_q      <= S_IDLE;
      strobe_n_q   <= 1'b1;
      line_ready_q <= 1'b0;
      err_q        <= 1'b0;
      trunc_q      <= 1'b0;
      count_q      <= '0;
      settle_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (line_ready_q) begin
            state_q <= S_HOLD;
          end else if (RXRDY) begin
            state_q    <= S_READ;
            strobe_n_q <= 1'b0;
          end
        end

        S_READ: begin
          strobe_n_q <= 1'b1;
          settle_q   <= '0;
          state_q    <= S_SETTLE;
          // An empty line is dropped together with whatever errors it carried.
          if (is_term && (count_q == '0)) begin
            err_q <= 1'b0;
          end else begin
            err_q <= err_q | byte_err;
          end
          if (is_term) begin
            if (count_q != '0) begin
              line_ready_q <= 1'b1;
              trunc_q      <= 1'b0;
            end
          end else if (!is_cr) begin
            count_q <= count_d;
            // A full buffer closes the line; the count never wraps.
            if (count_d == DEPTH_L) begin
              line_ready_q <= 1'b1;
              trunc_q      <= 1'b1;
            end
          end
        end

        S_SETTLE: begin
          // RXRDY lags the read; waiting here avoids reading one byte twice.
          if (!RXRDY || (settle_q == SETTLE_MAX)) begin
            state_q <= line_ready_q ? S_HOLD : S_IDLE;
          end else begin
            settle_q <= settle_q + 2'd1;
          end
        end

        S_HOLD: begin
          if (line_ack) begin
            line_ready_q <= 1'b0;
            count_q      <= '0;
            err_q        <= 1'b0;
            trunc_q      <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line buffer write port.
  always_ff @(posedge CLK) begin
    // NOTE: the buffer has no reset; count_q alone decides which entries are
    // valid, so clearing the storage would only cost logic.
    if (store_en && !RESET) begin
      buf_mem[count_q[ADDR_W-1:0]] <= UART_DATA;
    end
  end

  // Registered read port; addresses past the buffer return zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_q <= 8'h00;
    end else if (rd_addr < DEPTH_L) begin
      rd_data_q <= buf_mem[rd_addr[ADDR_W-1:0]];
    end else begin
      rd_data_q <= 8'h00;
    end
  end

  assign CSN        = strobe_n_q;
  assign OEN        = strobe_n_q;
  assign line_ready = line_ready_q;
  assign line_len   = count_q;
  assign line_err   = err_q;
  assign line_trunc = trunc_q;
  assign rd_data    = rd_data_q;

endmodule
